dram_write_sequencer: RTL and testbench



---
 rtl/dram_seq_pkg.sv | 28 ++
 rtl/dram_seq_fifo.sv | 50 +++++
 rtl/dram_write_sequencer.sv | 142 ++++++++++++++
 tb/tb_dram_write_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_seq_pkg.sv
// Shared types and constants for the DRAM write sequencer and its FIFO.
// Latency: n/a (declarations only). Backpressure: n/a.
package dram_seq_pkg;

    localparam int NUM_CORES = 16;
    localparam int LANE_W    = 64;
    localparam int ADDR_W    = 6;
    localparam int WBL_W     = NUM_CORES * LANE_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRECH = 2'd1,
        DRIVE = 2'd2,
        RECOV = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WBL_W-1:0]  data;
    } wr_entry_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dram_seq_fifo.sv
// Synchronous FIFO of write entries; head is visible combinationally.
// Latency: a push is visible at the head one cycle later. Backpressure: none; caller gates push with full/pop.
module dram_seq_fifo
    import dram_seq_pkg::*;
#(
    parameter int DEPTH = 64
)(
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     push,
    input  wr_entry_t                push_dat,
    input  logic                     pop,
    output wr_entry_t                head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    wr_entry_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define validity.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/dram_write_sequencer.sv
// Buffers row writes and replays each as precharge -> WL/WBL drive -> recovery; optional DRAM_SEQ_ADDR_CHECK_EN.
// Latency: push at edge n gives PRE in cycle n+1; one write per T_PRE+T_WL+T_REC cycles.
// Backpressure: none; requests arriving with the FIFO full (and no pop) are dropped and flag OVERFLOW.
module dram_write_sequencer
    import dram_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 64,
    parameter int T_PRE      = 2,
    parameter int T_WL       = 3,
    parameter int T_REC      = 1
)(
    input  logic              CLK,
    input  logic              RST,
    input  logic              IN_VALID,
    input  logic [ADDR_W-1:0] IN_ADDR,
    input  logic [WBL_W-1:0]  IN_WBL_DATA,
    output logic              PRE,
    output logic              WL_EN,
    output logic [ADDR_W-1:0] WL_ADDR,
    output logic              WBL_EN,
    output logic [WBL_W-1:0]  WBL_DATA,
    output logic              BUSY,
    output logic              OVERFLOW,
    output logic [6:0]        WR_COUNT,
    output logic              ADDR_ERR
);

    localparam int CW = $clog2(max3(T_PRE, T_WL, T_REC) + 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(T_PRE - 1);
    localparam logic [CW-1:0] WL_LAST  = CW'(T_WL - 1);
    localparam logic [CW-1:0] REC_LAST = CW'(T_REC - 1);

    seq_state_e   state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          pop;
    logic          push_ok;
    wr_entry_t     in_entry;
    wr_entry_t     fifo_head;
    wr_entry_t     cur_q;
    logic          fifo_full;
    logic          fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    assign in_entry = '{addr: IN_ADDR, data: IN_WBL_DATA};
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push_ok  = IN_VALID && (!fifo_full || pop);

    dram_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK      (CLK),
        .RST      (RST),
        .push     (push_ok),
        .push_dat (in_entry),
        .pop      (pop),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + CW'(1);
        pop      = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (!fifo_empty) state_nx = PRECH;
            end
            PRECH: begin
                if (cnt == PRE_LAST) begin
                    state_nx = DRIVE;
                    cnt_nx   = '0;
                end
            end
            DRIVE: begin
                if (cnt == WL_LAST) begin
                    state_nx = RECOV;
                    cnt_nx   = '0;
                    pop      = 1'b1;
                end
            end
            RECOV: begin
                if (cnt == REC_LAST) begin
                    state_nx = fifo_empty ? IDLE : PRECH;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            PRE      <= 1'b0;
            WL_EN    <= 1'b0;
            WBL_EN   <= 1'b0;
            cur_q    <= '0;
            OVERFLOW <= 1'b0;
            WR_COUNT <= '0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            PRE    <= (state_nx == PRECH);
            WL_EN  <= (state_nx == DRIVE);
            WBL_EN <= (state_nx == DRIVE);
            // Head is captured once per write and held until the next PRECH or IDLE.
            if (state_nx == PRECH && state != PRECH) cur_q <= fifo_head;
            else if (state_nx == IDLE)               cur_q <= '0;
            if (IN_VALID && !push_ok)                OVERFLOW <= 1'b1;
            if (pop && WR_COUNT != 7'd127)           WR_COUNT <= WR_COUNT + 7'd1;
        end
    end

    assign WL_ADDR  = cur_q.addr;
    assign WBL_DATA = cur_q.data;
    assign BUSY     = (fifo_count != '0) || (state != IDLE);

`ifdef DRAM_SEQ_ADDR_CHECK_EN
    logic [ADDR_W-1:0] prev_addr;
    logic              have_prev;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prev_addr <= '0;
            have_prev <= 1'b0;
            ADDR_ERR  <= 1'b0;
        end else if (push_ok) begin
            if (have_prev && IN_ADDR != prev_addr + ADDR_W'(1)) ADDR_ERR <= 1'b1;
            prev_addr <= IN_ADDR;
            have_prev <= 1'b1;
        end
    end
`else
    assign ADDR_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_dram_write_sequencer.sv
// Bench for dram_write_sequencer: schedule-level reference model checked every cycle plus hand-pinned cases.
module tb_dram_write_sequencer;

    localparam int DEPTH = 64;
    localparam int TP    = 2;
    localparam int TW    = 3;
    localparam int TR    = 1;
    localparam int L     = TP + TW + TR;
    localparam int MAXN  = 512;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          IN_VALID = 1'b0;
    logic [5:0]    IN_ADDR = '0;
    logic [1023:0] IN_WBL_DATA = '0;
    logic          PRE, WL_EN, WBL_EN, BUSY, OVERFLOW, ADDR_ERR;
    logic [5:0]    WL_ADDR;
    logic [1023:0] WBL_DATA;
    logic [6:0]    WR_COUNT;

    dram_write_sequencer #(.FIFO_DEPTH(DEPTH), .T_PRE(TP), .T_WL(TW), .T_REC(TR)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_ADDR(IN_ADDR), .IN_WBL_DATA(IN_WBL_DATA),
        .PRE(PRE), .WL_EN(WL_EN), .WL_ADDR(WL_ADDR), .WBL_EN(WBL_EN), .WBL_DATA(WBL_DATA),
        .BUSY(BUSY), .OVERFLOW(OVERFLOW), .WR_COUNT(WR_COUNT), .ADDR_ERR(ADDR_ERR)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    // Model: every accepted write has a push edge and a start cycle; all outputs follow from those.
    int            m_n;
    int            m_p [MAXN];
    int            m_s [MAXN];
    logic [5:0]    m_a [MAXN];
    logic [1023:0] m_d [MAXN];
    bit            m_ovf, m_aerr, m_have_prev;
    logic [5:0]    m_prev;

    task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [1023:0] rnd_data();
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_clear();
        m_n = 0;
        m_ovf = 1'b0;
        m_aerr = 1'b0;
        m_have_prev = 1'b0;
        m_prev = '0;
    endtask

    task automatic model_edge(input logic v, input logic [5:0] a, input logic [1023:0] d);
        int  e;
        int  occ;
        bit  popping;
        int  s;
        e = cyc;
        occ = 0;
        popping = 1'b0;
        if (v) begin
            for (int k = 0; k < m_n; k++) begin
                if (m_p[k] < e && m_s[k] + TP + TW >= e) occ++;
                if (m_s[k] + TP + TW == e) popping = 1'b1;
            end
            if (occ < DEPTH || popping) begin
                if (m_have_prev && a != m_prev + 6'd1) m_aerr = 1'b1;
                m_prev = a;
                m_have_prev = 1'b1;
                s = e + 1;
                if (m_n > 0 && m_s[m_n-1] + L > s) s = m_s[m_n-1] + L;
                if (m_n < MAXN) begin
                    m_p[m_n] = e;
                    m_s[m_n] = s;
                    m_a[m_n] = a;
                    m_d[m_n] = d;
                    m_n++;
                end else begin
                    n_err++;
                    $display("FAIL model_capacity: got %0d entries, expected below %0d", m_n, MAXN);
                end
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic compare_cycle();
        int            c;
        int            ncomp;
        int            ph;
        logic          e_pre, e_drv, e_busy, e_aerr;
        logic [5:0]    e_addr;
        logic [1023:0] e_data;
        logic [6:0]    e_cnt;
        c = cyc;
        ncomp = 0;
        e_pre = 1'b0; e_drv = 1'b0; e_busy = 1'b0;
        e_addr = '0; e_data = '0;
        for (int k = 0; k < m_n; k++) begin
            if (c >= m_s[k] && c < m_s[k] + L) begin
                ph = c - m_s[k];
                e_pre = (ph < TP);
                e_drv = (ph >= TP && ph < TP + TW);
                e_addr = m_a[k];
                e_data = m_d[k];
            end
            if (c >= m_p[k] && c < m_s[k] + L) e_busy = 1'b1;
            if (m_s[k] + TP + TW <= c) ncomp++;
        end
        e_cnt = (ncomp > 127) ? 7'd127 : 7'(ncomp);
`ifdef DRAM_SEQ_ADDR_CHECK_EN
        e_aerr = m_aerr;
`else
        e_aerr = 1'b0;
`endif
        chk("pre", PRE, e_pre);
        chk("wl_en", WL_EN, e_drv);
        chk("wbl_en", WBL_EN, e_drv);
        chk("wl_addr", WL_ADDR, e_addr);
        chk("wbl_data", WBL_DATA, e_data);
        chk("busy", BUSY, e_busy);
        chk("overflow", OVERFLOW, m_ovf);
        chk("wr_count", WR_COUNT, e_cnt);
        chk("addr_err", ADDR_ERR, e_aerr);
    endtask

    always @(negedge CLK) begin
        if (chk_en) compare_cycle();
    end

    task automatic step(input logic v, input logic [5:0] a, input logic [1023:0] d);
        IN_VALID = v;
        IN_ADDR = a;
        IN_WBL_DATA = d;
        @(posedge CLK);
        cyc++;
        model_edge(v, a, d);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 6'd0, '0);
    endtask

    task automatic assert_rst();
        chk_en = 1'b0;
        IN_VALID = 1'b0;
        #1 RST = 1'b1;
    endtask

    task automatic release_rst();
        repeat (2) @(posedge CLK);
        #3 RST = 1'b0;
        model_clear();
        cyc = 0;
        chk_en = 1'b1;
    endtask

    logic [1023:0] lanes;
    logic [5:0]    seq_a;
    logic [5:0]    ra;
    logic          rv;
    int            busy_cnt;
    int            pct;

    initial begin
        model_clear();
        for (int k = 0; k < 16; k++) lanes[64*k +: 64] = 64'h0001020304050607;

        // Reset state
        #3;
        chk("rst_pre", PRE, 1'b0);
        chk("rst_wl_en", WL_EN, 1'b0);
        chk("rst_wbl_en", WBL_EN, 1'b0);
        chk("rst_wl_addr", WL_ADDR, 6'd0);
        chk("rst_wbl_data", WBL_DATA, '0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_overflow", OVERFLOW, 1'b0);
        chk("rst_wr_count", WR_COUNT, 7'd0);
        chk("rst_addr_err", ADDR_ERR, 1'b0);
        release_rst();

        // Single write, addr 5: pushed at edge 1, PRE cycles 2-3, drive 4-6, idle from 8
        step(1'b1, 6'd5, lanes);
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 6'd0, '0);
            if (cyc == 2 || cyc == 3) begin
                chk("single_pre", PRE, 1'b1);
                chk("single_wl_off", WL_EN, 1'b0);
            end
            if (cyc >= 4 && cyc <= 6) begin
                chk("single_pre_off", PRE, 1'b0);
                chk("single_wl_en", WL_EN, 1'b1);
                chk("single_wbl_en", WBL_EN, 1'b1);
                chk("single_addr", WL_ADDR, 6'd5);
                chk("single_data", WBL_DATA, lanes);
            end
            if (cyc == 7) begin
                chk("single_recov_strobes", {PRE, WL_EN, WBL_EN}, 3'b000);
                chk("single_count", WR_COUNT, 7'd1);
                chk("single_busy_recov", BUSY, 1'b1);
            end
            if (cyc == 8) begin
                chk("single_busy_low", BUSY, 1'b0);
                chk("single_addr_idle", WL_ADDR, 6'd0);
            end
        end

        // 54-write burst: busy without a gap for 1 + 54*6 cycles
        assert_rst();
        release_rst();
        busy_cnt = 0;
        for (int i = 0; i < 54; i++) begin
            step(1'b1, 6'(i), rnd_data());
            if (BUSY) busy_cnt++;
        end
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 6'd0, '0);
            if (BUSY) busy_cnt++;
        end
        chk("burst_busy_cycles", 32'(busy_cnt), 32'd325);
        chk("burst_overflow", OVERFLOW, 1'b0);
        chk("burst_count", WR_COUNT, 7'd54);

        // 80 back-to-back pushes overflow the FIFO; total completions pass 127
        for (int i = 0; i < 80; i++) step(1'b1, 6'(i), rnd_data());
        idle(420);
        chk("ovf_flag", OVERFLOW, 1'b1);
        chk("ovf_count_sat", WR_COUNT, 7'd127);
        chk("ovf_busy_done", BUSY, 1'b0);

        // Address sequence 0, 1, 3
        assert_rst();
        release_rst();
        step(1'b1, 6'd0, rnd_data());
        step(1'b1, 6'd1, rnd_data());
        chk("aseq_ok", ADDR_ERR, 1'b0);
        step(1'b1, 6'd3, rnd_data());
`ifdef DRAM_SEQ_ADDR_CHECK_EN
        chk("aseq_err", ADDR_ERR, 1'b1);
        idle(5);
        chk("aseq_sticky", ADDR_ERR, 1'b1);
`else
        chk("aseq_err", ADDR_ERR, 1'b0);
        idle(5);
        chk("aseq_sticky", ADDR_ERR, 1'b0);
`endif
        idle(20);

        // Reset during drive of write 2 of 3
        assert_rst();
        release_rst();
        step(1'b1, 6'd10, rnd_data());
        step(1'b1, 6'd11, rnd_data());
        step(1'b1, 6'd12, rnd_data());
        while (cyc < 10) step(1'b0, 6'd0, '0);
        chk("midrst_drive", WL_EN, 1'b1);
        chk("midrst_addr", WL_ADDR, 6'd11);
        chk("midrst_count_before", WR_COUNT, 7'd1);
        assert_rst();
        #1;
        chk("midrst_pre", PRE, 1'b0);
        chk("midrst_wl_en", WL_EN, 1'b0);
        chk("midrst_wbl_en", WBL_EN, 1'b0);
        chk("midrst_wl_addr", WL_ADDR, 6'd0);
        chk("midrst_wbl_data", WBL_DATA, '0);
        chk("midrst_busy", BUSY, 1'b0);
        chk("midrst_count", WR_COUNT, 7'd0);
        release_rst();
        idle(30);
        chk("midrst_quiet", {PRE, WL_EN, WBL_EN, BUSY}, 4'b0000);

        // Randomized traffic: light load, then heavy load to force drops
        assert_rst();
        release_rst();
        seq_a = 6'($urandom);
        for (int i = 0; i < 700; i++) begin
            pct = (i < 300) ? 20 : 90;
            rv = ($urandom_range(0, 99) < pct);
            ra = ($urandom_range(0, 7) == 0) ? 6'($urandom) : seq_a;
            if (rv) seq_a = ra + 6'd1;
            step(rv, ra, rnd_data());
        end
        idle(420);
        chk("rand_busy_done", BUSY, 1'b0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
